// File: rtl/ahb_to_apb_bridge_mux.sv
// AHB-Lite slave to multi-slave APB4 bridge on a single clock.
// APB progress is paced by i_pclken; the selected slave is decoded from the
// slot field of the AHB address and its response signals are muxed back.
// Decode misses, bad size/alignment, PSLVERR and APB timeouts all produce a
// two-cycle AHB ERROR response.
module ahb_to_apb_bridge_mux #(
    parameter int NUM_SLV     = 4,
    parameter int SLOT_LSB    = 12,
    parameter int PADDR_WIDTH = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                     i_hclk,
    input  logic                     i_hreset,
    input  logic                     i_hsel,
    input  logic [31:0]              i_haddr,
    input  logic [1:0]               i_htrans,
    input  logic                     i_hwrite,
    input  logic [2:0]               i_hsize,
    input  logic [3:0]               i_hprot,
    input  logic [31:0]              i_hwdata,
    input  logic                     i_hreadyin,
    output logic                     o_hreadyout,
    output logic [1:0]               o_hresp,
    output logic [31:0]              o_hrdata,
    input  logic                     i_pclken,
    output logic [NUM_SLV-1:0]       o_psel,
    output logic                     o_penable,
    output logic [PADDR_WIDTH-1:0]   o_paddr,
    output logic                     o_pwrite,
    output logic [31:0]              o_pwdata,
    output logic [3:0]               o_pstrb,
    output logic [2:0]               o_pprot,
    input  logic [32*NUM_SLV-1:0]    i_prdata,
    input  logic [NUM_SLV-1:0]       i_pready,
    input  logic [NUM_SLV-1:0]       i_pslverr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SETUP, S_ACCESS, S_ERR} state_t;

    state_t                   r_state, w_state_next;
    logic                     r_hreadyout, w_hreadyout_next;
    logic [1:0]               r_hresp, w_hresp_next;
    logic [31:0]              r_hrdata, w_hrdata_next;
    logic [NUM_SLV-1:0]       r_psel, w_psel_next;
    logic                     r_penable, w_penable_next;
    logic [PADDR_WIDTH-1:0]   r_paddr, w_paddr_next;
    logic                     r_pwrite, w_pwrite_next;
    logic [31:0]              r_pwdata, w_pwdata_next;
    logic [3:0]               r_pstrb, w_pstrb_next;
    logic [2:0]               r_pprot, w_pprot_next;
    logic [NUM_SLV-1:0]       r_slot_oh, w_slot_oh_next;
    logic [31:0]              r_timer, w_timer_next;

    logic [3:0]               w_slot;
    logic [NUM_SLV-1:0]       w_dec_oh;
    logic [NUM_SLV-1:0][31:0] w_rd_lane;
    logic [31:0]              w_prdata;
    logic                     w_pready;
    logic                     w_pslverr;
    logic [3:0]               w_strb;
    logic                     w_req_bad;
    logic                     w_timeout_hit;
    logic                     w_unused;

    assign w_unused = ^{i_haddr, i_hprot, i_htrans};
    assign w_slot   = i_haddr[SLOT_LSB+3:SLOT_LSB];

    // Per-slave address decode and masking of each slave's read data lane
    // by the slot latched at the start of the transfer.
    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign w_dec_oh[gi]  = (w_slot == 4'(gi));
        assign w_rd_lane[gi] = i_prdata[32*gi +: 32] & {32{r_slot_oh[gi]}};
    end

    // OR together the masked lanes; only the latched slot can be non-zero.
    always_comb begin
        w_prdata = 32'd0;
        for (int n = 0; n < NUM_SLV; n++) begin
            w_prdata = w_prdata | w_rd_lane[n];
        end
    end

    assign w_pready      = |(i_pready & r_slot_oh);
    assign w_pslverr     = |(i_pslverr & r_slot_oh);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

    // Little-endian byte strobes from size and low address bits.
    always_comb begin
        case (i_hsize)
            3'b000:  w_strb = 4'b0001 << i_haddr[1:0];
            3'b001:  w_strb = i_haddr[1] ? 4'b1100 : 4'b0011;
            3'b010:  w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
    end

    // A request is refused without an APB cycle on a decode miss, an
    // oversized transfer, or a misaligned halfword/word.
    assign w_req_bad = (~|w_dec_oh) || (i_hsize > 3'b010) ||
                       ((i_hsize == 3'b001) && i_haddr[0]) ||
                       ((i_hsize == 3'b010) && (i_haddr[1:0] != 2'b00));

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        w_state_next     = r_state;
        w_hreadyout_next = r_hreadyout;
        w_hresp_next     = r_hresp;
        w_hrdata_next    = r_hrdata;
        w_psel_next      = r_psel;
        w_penable_next   = r_penable;
        w_paddr_next     = r_paddr;
        w_pwrite_next    = r_pwrite;
        w_pwdata_next    = r_pwdata;
        w_pstrb_next     = r_pstrb;
        w_pprot_next     = r_pprot;
        w_slot_oh_next   = r_slot_oh;
        w_timer_next     = r_timer;
        case (r_state)
            S_IDLE: begin
                w_hreadyout_next = 1'b1;
                w_hresp_next     = 2'b00;
                if (i_hsel && i_hreadyin && i_htrans[1]) begin
                    w_paddr_next     = i_haddr[PADDR_WIDTH-1:0];
                    w_pwrite_next    = i_hwrite;
                    w_pprot_next     = {~i_hprot[0], 1'b1, i_hprot[1]};
                    w_slot_oh_next   = w_dec_oh;
                    w_pstrb_next     = i_hwrite ? w_strb : 4'b0000;
                    w_hreadyout_next = 1'b0;
                    if (w_req_bad) begin
                        w_hresp_next = 2'b01;
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Write data arrives in the AHB data phase, i.e. while here.
                w_pwdata_next = i_hwdata;
                if (i_pclken) begin
                    w_psel_next  = r_slot_oh;
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (i_pclken) begin
                    w_penable_next = 1'b1;
                    w_timer_next   = 32'd0;
                    w_state_next   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (i_pclken) begin
                    if (w_pready) begin
                        w_psel_next    = '0;
                        w_penable_next = 1'b0;
                        if (w_pslverr) begin
                            w_hresp_next = 2'b01;
                            w_state_next = S_ERR;
                        end else begin
                            if (!r_pwrite) begin
                                w_hrdata_next = w_prdata;
                            end
                            w_hreadyout_next = 1'b1;
                            w_state_next     = S_IDLE;
                        end
                    end else if (w_timeout_hit) begin
                        w_psel_next    = '0;
                        w_penable_next = 1'b0;
                        w_hresp_next   = 2'b01;
                        w_state_next   = S_ERR;
                    end else begin
                        w_timer_next = r_timer + 32'd1;
                    end
                end
            end
            S_ERR: begin
                // Second ERROR cycle: HRESP stays 01 while HREADYOUT rises.
                w_hreadyout_next = 1'b1;
                w_state_next     = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any APB cycle at once.
    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_hrdata    <= 32'd0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'd0;
            r_pstrb     <= 4'd0;
            r_pprot     <= 3'd0;
            r_slot_oh   <= '0;
            r_timer     <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_hreadyout <= w_hreadyout_next;
            r_hresp     <= w_hresp_next;
            r_hrdata    <= w_hrdata_next;
            r_psel      <= w_psel_next;
            r_penable   <= w_penable_next;
            r_paddr     <= w_paddr_next;
            r_pwrite    <= w_pwrite_next;
            r_pwdata    <= w_pwdata_next;
            r_pstrb     <= w_pstrb_next;
            r_pprot     <= w_pprot_next;
            r_slot_oh   <= w_slot_oh_next;
            r_timer     <= w_timer_next;
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = r_hrdata;
    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_paddr     = r_paddr;
    assign o_pwrite    = r_pwrite;
    assign o_pwdata    = r_pwdata;
    assign o_pstrb     = r_pstrb;
    assign o_pprot     = r_pprot;

endmodule
